// File: rtl/hazard_pkg.sv
// Shared types and defaults for the fetch/decode hazard controller.
// Pure declarations: no logic, no latency, no flow control.
// State encoding, default widths and the NOP word that a flushed IF/ID holds.
package hazard_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int REG_AW_DEF = 5;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        IMEM_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: EX load writes a register the ID instruction reads.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the consumer decides whether to stall.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    output logic              lu
);

    // r0 is hardwired to zero, so a load into it never creates a dependency.
    assign lu = ex_memread && (ex_rd != '0) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// PC / IF-ID sequencing from load-use, taken jumps and imem ready; HAZ_STATS_EN adds counters.
// Latency: Mealy outputs, stalls and flushes act in the same cycle as their cause.
// Backpressure: imem_ready low freezes PC and IF/ID; pc_target and fetch_err are registered.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int FLUSH_CYC = 1,
    parameter int MAX_WAIT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic              pc_we,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              fetch_err
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
    output logic [15:0]       wait_cnt
`endif
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam int CNT_W  = 2;

    hz_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              pend_jump, pend_nxt;
    logic [ADDR_W-1:0] tgt_nxt;
    logic              err_nxt;
    logic              lu;
    logic              jump_eff;

    load_use_detect #(.REG_AW(REG_AW)) u_lu (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .lu         (lu)
    );

    // A jump seen while waiting on imem is replayed on the cycle imem returns.
    assign jump_eff = jump_i || ((state == IMEM_WAIT) && pend_jump);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wcnt_nxt    = wcnt;
        pend_nxt    = pend_jump;
        tgt_nxt     = pc_target;
        err_nxt     = fetch_err;
        imem_req    = 1'b1;
        pc_we       = 1'b1;
        pc_sel      = 1'b0;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        if (state == FLUSH) begin
            ifid_flush = 1'b1;
            cnt_nxt    = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1))
                state_nxt = RUN;
        end else if ((state == IMEM_WAIT) && !imem_ready) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            if (jump_i) begin
                pend_nxt = 1'b1;
                tgt_nxt  = jump_target;
            end
            if (wcnt == WCNT_W'(MAX_WAIT))
                err_nxt = 1'b1;
            else
                wcnt_nxt = wcnt + WCNT_W'(1);
        end else begin
            // RUN, or the IMEM_WAIT cycle in which imem comes back.
            state_nxt = RUN;
            pend_nxt  = 1'b0;
            if (jump_eff) begin
                pc_sel     = 1'b1;
                ifid_flush = 1'b1;
                if (jump_i)
                    tgt_nxt = jump_target;
                cnt_nxt = CNT_W'(FLUSH_CYC - 1);
                if (FLUSH_CYC > 1)
                    state_nxt = FLUSH;
            end else if (!imem_ready) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                ifid_flush = 1'b1;
                state_nxt  = IMEM_WAIT;
                wcnt_nxt   = WCNT_W'(1);
            end else if (lu) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end
        end

        if (!rst_n) begin
            imem_req    = 1'b0;
            pc_we       = 1'b0;
            pc_sel      = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            cnt       <= '0;
            wcnt      <= '0;
            pend_jump <= 1'b0;
            pc_target <= '0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wcnt      <= wcnt_nxt;
            pend_jump <= pend_nxt;
            pc_target <= tgt_nxt;
            fetch_err <= err_nxt;
        end
    end

`ifdef HAZ_STATS_EN
    logic lu_stall, jmp_flush, in_wait;

    assign lu_stall  = rst_n && idex_bubble;
    assign jmp_flush = rst_n && (pc_sel || (state == FLUSH));
    assign in_wait   = (state == IMEM_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (lu_stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (jmp_flush && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
            if (in_wait && (wait_cnt != 16'hFFFF))
                wait_cnt <= wait_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios, then randomized traffic.
// A cycle-level behavioural model checks every output on each falling edge.
module tb_pipe_hazard_ctrl;

    localparam int ADDR_W    = 14;
    localparam int REG_AW    = 5;
    localparam int FLUSH_CYC = 2;
    localparam int MAX_WAIT  = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
    logic              id_uses_rt, ex_memread, jump_i, imem_ready;
    logic [ADDR_W-1:0] jump_target;
    logic              imem_req, pc_we, pc_sel, ifid_we, ifid_flush, idex_bubble, fetch_err;
    logic [ADDR_W-1:0] pc_target;
`ifdef HAZ_STATS_EN
    logic [15:0]       stall_cnt, flush_cnt, wait_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .ADDR_W(ADDR_W), .REG_AW(REG_AW), .FLUSH_CYC(FLUSH_CYC), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .jump_i(jump_i), .jump_target(jump_target), .imem_ready(imem_ready),
        .imem_req(imem_req), .pc_we(pc_we), .pc_sel(pc_sel), .pc_target(pc_target),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fetch_err(fetch_err)
`ifdef HAZ_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: remaining flush cycles, whether fetch is waiting on imem,
    // consecutive not-ready cycles, a remembered jump, the target and the error flag.
    int                m_flush = 0;
    int                m_wcnt  = 0;
    bit                m_wait  = 0;
    bit                m_pend  = 0;
    bit                m_err   = 0;
    logic [ADDR_W-1:0] m_tgt   = '0;

    initial begin : model
        int                nf, nw;
        bit                nwait, npend, nerr, lu, jmp;
        bit                e_req, e_we, e_sel, e_ifwe, e_fl, e_bub;
        logic [ADDR_W-1:0] nt;
        forever begin
            @(negedge clk);
            nf = m_flush; nw = m_wcnt; nwait = m_wait; npend = m_pend; nerr = m_err; nt = m_tgt;
            lu = ex_memread && (ex_rd != 0) &&
                 ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
            {e_req, e_we, e_sel, e_ifwe, e_fl, e_bub} = 6'b110100;
            if (!rst_n) begin
                {e_req, e_we, e_sel, e_ifwe, e_fl, e_bub} = 6'b000011;
                nf = 0; nw = 0; nwait = 0; npend = 0; nerr = 0; nt = '0;
            end else if (m_flush > 0) begin
                e_fl = 1; nf = m_flush - 1;
            end else if (m_wait && !imem_ready) begin
                e_we = 0; e_ifwe = 0; e_fl = 1;
                if (jump_i) begin npend = 1; nt = jump_target; end
                if (m_wcnt >= MAX_WAIT) nerr = 1;
                nw = (m_wcnt < MAX_WAIT) ? m_wcnt + 1 : MAX_WAIT;
            end else begin
                jmp = jump_i || (m_wait && m_pend);
                nwait = 0; npend = 0;
                if (jmp) begin
                    e_sel = 1; e_fl = 1; nf = FLUSH_CYC - 1;
                    if (jump_i) nt = jump_target;
                end else if (!imem_ready) begin
                    e_we = 0; e_ifwe = 0; e_fl = 1; nwait = 1; nw = 1;
                end else if (lu) begin
                    e_we = 0; e_ifwe = 0; e_bub = 1;
                end
            end
            chk("m_imem_req", imem_req, e_req);
            chk("m_pc_we", pc_we, e_we);
            chk("m_pc_sel", pc_sel, e_sel);
            chk("m_ifid_we", ifid_we, e_ifwe);
            chk("m_ifid_flush", ifid_flush, e_fl);
            chk("m_idex_bubble", idex_bubble, e_bub);
            chk("m_pc_target", pc_target, rst_n ? m_tgt : '0);
            chk("m_fetch_err", fetch_err, rst_n ? m_err : 1'b0);
            @(posedge clk);
            m_flush = nf; m_wcnt = nw; m_wait = nwait; m_pend = npend; m_err = nerr; m_tgt = nt;
        end
    end

    task automatic idle();
        jump_i = 0; jump_target = '0; imem_ready = 1; ex_memread = 0;
        ex_rd = '0; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin : driver
        int burst = 0;
        idle();
        rst_n = 0;
        smp();
        chk("rst_flush", ifid_flush, 1); chk("rst_pc_we", pc_we, 0);
        chk("rst_bubble", idex_bubble, 1); chk("rst_req", imem_req, 0);
        nxt(); rst_n = 1;
        smp(); chk("run_pc_we", pc_we, 1);

        // load-use on rs, then the load moves on
        nxt(); ex_memread = 1; ex_rd = 5'd8; id_rs = 5'd8;
        smp(); chk("lu_pc_we", pc_we, 0); chk("lu_ifid_we", ifid_we, 0); chk("lu_bubble", idex_bubble, 1);
        nxt(); ex_memread = 0;
        smp(); chk("lu_clear", idex_bubble, 0); chk("lu_clear_we", pc_we, 1);
        nxt(); ex_memread = 1; ex_rd = '0; id_rs = '0;
        smp(); chk("lu_r0_pc_we", pc_we, 1); chk("lu_r0_bubble", idex_bubble, 0);

        // jump wins over a simultaneous load-use
        nxt(); ex_rd = 5'd8; id_rs = 5'd8; jump_i = 1; jump_target = 14'h0040;
        smp(); chk("jmp_sel", pc_sel, 1); chk("jmp_flush", ifid_flush, 1); chk("jmp_no_bubble", idex_bubble, 0);
        nxt(); idle();
        smp(); chk("jmp_tgt", pc_target, 32'h40); chk("jmp_flush2", ifid_flush, 1);
        nxt(); smp(); chk("jmp_flush_end", ifid_flush, 0);

        // three-cycle imem stall
        for (int i = 0; i < 3; i++) begin
            nxt(); imem_ready = 0;
            smp(); chk("stall_pc_we", pc_we, 0); chk("stall_flush", ifid_flush, 1);
        end
        nxt(); imem_ready = 1;
        smp(); chk("stall_exit_pc_we", pc_we, 1); chk("stall_err", fetch_err, 0);

        // jump arriving in the second wait cycle
        nxt(); imem_ready = 0; smp();
        nxt(); jump_i = 1; jump_target = 14'h0100;
        smp(); chk("wj_hold", pc_we, 0);
        nxt(); jump_i = 0; imem_ready = 1;
        smp(); chk("wj_sel", pc_sel, 1); chk("wj_tgt", pc_target, 32'h100);
        nxt(); smp(); chk("wj_flush", ifid_flush, 1);
        nxt(); smp();

        // timeout after 16 not-ready cycles; sticky afterwards
        for (int i = 0; i < 16; i++) begin
            nxt(); imem_ready = 0;
        end
        smp(); chk("to_not_yet", fetch_err, 0);
        nxt(); imem_ready = 1;
        smp(); chk("to_err", fetch_err, 1);
        repeat (3) nxt();
        smp(); chk("to_sticky", fetch_err, 1);

        // reset asserted while in FLUSH
        nxt(); jump_i = 1; jump_target = 14'h0222; smp();
        nxt(); jump_i = 0; rst_n = 0;
        smp(); chk("rstf_flush", ifid_flush, 1); chk("rstf_err", fetch_err, 0); chk("rstf_tgt", pc_target, 0);
        nxt(); rst_n = 1;
        smp(); chk("rstf_run", ifid_flush, 0); chk("rstf_pc_we", pc_we, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nxt();
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 299) == 0) rst_n = 0;
            jump_i      = ($urandom_range(0, 9) == 0);
            jump_target = ADDR_W'($urandom);
            if (burst > 0) begin
                imem_ready = 0; burst--;
            end else if ($urandom_range(0, 19) == 0) begin
                imem_ready = 0; burst = $urandom_range(0, 20);
            end else begin
                imem_ready = 1;
            end
            ex_memread = 1'($urandom_range(0, 1));
            ex_rd      = REG_AW'($urandom_range(0, 3));
            id_rs      = REG_AW'($urandom_range(0, 3));
            id_rt      = REG_AW'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
        end
        nxt(); idle(); smp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequences the IF/ID pipeline register and the PC.
- Generates PC write-enable, IF/ID write-enable/flush and ID/EX bubble from load-use hazards, taken jumps and the instruction-memory ready handshake.
- Sits beside the IF/ID register; its flush output replaces the raw jump flush, and its enables gate the fetch stage.

Parameters:
- ADDR_W, 14, instruction address width (matches IF/ID address field)
- REG_AW, 5, register-index width
- FLUSH_CYC, 1, cycles IF/ID is flushed after a taken jump (1..3)
- MAX_WAIT, 15, max consecutive imem-not-ready cycles before fetch_err

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  REG_AW  rs field of instruction in ID
- id_rt  in  REG_AW  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  REG_AW  destination register of EX instruction
- jump_i  in  1  taken jump/branch resolved in ID, one-cycle pulse
- jump_target  in  ADDR_W  target address of jump_i
- imem_ready  in  1  instruction memory returns valid data this cycle
- imem_req  out  1  fetch request
- pc_we  out  1  PC write enable
- pc_sel  out  1  1: PC loads pc_target; 0: sequential
- pc_target  out  ADDR_W  registered jump target
- ifid_we  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clears to zero (NOP) at next edge
- idex_bubble  out  1  ID/EX receives control-zero bubble
- fetch_err  out  1  sticky imem timeout flag

Behaviour:
- Reset (async, rst_n=0): state=RUN, counters=0, pend_jump=0, pc_target=0, fetch_err=0. Outputs while in reset: imem_req=0, pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pc_sel=0.
- The state register is clocked. Outputs are combinational from state plus the current inputs (Mealy), so a stall takes effect in the same cycle as the condition (zero latency).
- Load-use condition lu = ex_memread & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- RUN: imem_req=1, pc_we=1, ifid_we=1. Evaluated in priority order, highest first:
  - jump_i=1: pc_sel=1, pc_target<=jump_target, ifid_flush=1, idex_bubble=0; go to FLUSH with cnt=FLUSH_CYC-1, or stay in RUN if FLUSH_CYC==1.
  - imem_ready=0: pc_we=0, ifid_we=0, ifid_flush=1; go to IMEM_WAIT with wcnt=1.
  - lu=1: pc_we=0, ifid_we=0, idex_bubble=1. Stay in RUN; the hazard clears next cycle once the load advances.
  - otherwise: all enables asserted.
- FLUSH: ifid_flush=1, pc_we=1 (sequential from target), imem_req=1. Decrement cnt; go to RUN at 0. A new jump_i in FLUSH is ignored, since the flushed slot holds a NOP.
- IMEM_WAIT: pc_we=0, ifid_we=0, ifid_flush=1, imem_req=1.
  - jump_i=1: set pend_jump=1 and latch jump_target.
  - imem_ready=1: go to RUN. If pend_jump, that cycle behaves as the RUN jump case using the latched target, then pend_jump clears.
  - wcnt==MAX_WAIT with imem_ready=0: set fetch_err=1 and stay in IMEM_WAIT. fetch_err clears only on reset.
- wcnt saturates at MAX_WAIT. It is sized clog2(MAX_WAIT+1).
- Jump and load-use in the same cycle: the jump wins. The load-use instruction is flushed, so no bubble is needed.
- pc_target holds its value between jumps.

Optional Feature:
- Macro HAZ_STATS_EN.
- Defined: adds outputs stall_cnt[15:0], flush_cnt[15:0] and wait_cnt[15:0].
  - stall_cnt counts load-use stall cycles; flush_cnt counts ifid_flush cycles caused by jumps; wait_cnt counts IMEM_WAIT cycles.
  - All saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - state enum {RUN, FLUSH, IMEM_WAIT}, 2-bit
  - ADDR_W/REG_AW defaults
  - NOP instruction constant 32'h00000000
- Sub-module load_use_detect: purely combinational lu comparator, reusable by the forwarding unit.

Test Plan:
- Reset: hold rst_n=0 mid-stream in FLUSH, then release. Expect state RUN, fetch_err=0, pc_target=0, and ifid_flush=1 while reset is low.
- Load-use: ex_memread=1, ex_rd=8, id_rs=8, imem_ready=1. Expect pc_we=0, ifid_we=0, idex_bubble=1 for exactly 1 cycle. Repeat with ex_rd=0: no stall.
- Jump, FLUSH_CYC=2: jump_i pulse with jump_target=14'h0040. Expect pc_sel=1 and pc_target=0x0040 next cycle, then ifid_flush=1 for 2 cycles; a simultaneous lu produces no idex_bubble.
- imem stall: imem_ready=0 for 3 cycles. Expect pc_we=0, ifid_we=0, ifid_flush=1 for 3 cycles, then RUN with fetch_err=0.
- Jump during wait: jump_i with target 0x0100 in cycle 2 of IMEM_WAIT, then imem_ready=1. Expect pc_sel=1 and pc_target=0x0100 on the ready cycle, then the flush.
- Timeout, MAX_WAIT=15: hold imem_ready=0 for 16 cycles. Expect fetch_err=1 that stays high after ready returns, until rst_n=0.
